// File: rtl/osc_pkg.sv
// Shared constants and types for the oscilloscope capture and trace drawing path.
package osc_pkg;

    localparam int SAMPLES     = 400;
    localparam int DW          = 12;
    localparam int AW          = 9;
    localparam int AUTO_FRAMES = 4;

    typedef enum logic [1:0] {ARMED, CAPTURE, FULL} cap_state_t;

    typedef logic [DW-1:0] sample_t;

endpackage

// File: rtl/trace_ram.sv
// Two-bank trace store: one write port, one registered read port, shaped for BRAM inference.
// Latency: 1 cycle read. No backpressure; both ports accept every cycle.
module trace_ram #(
    parameter int DW = 12,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW:0]   rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(2**(AW+1))-1];
    logic [DW-1:0] rd_data_q;

    // Contents are deliberately left unreset; the controller masks unwritten banks.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_buffer_ctrl.sv
// Double-buffered triggered sample capture; display bank swaps only on frame_start.
// Latency: 1 cycle rd_addr to rd_data. No backpressure; samples arriving in FULL are dropped.
module trace_buffer_ctrl #(
    parameter int SAMPLES     = osc_pkg::SAMPLES,
    parameter int DW          = osc_pkg::DW,
    parameter int AW          = osc_pkg::AW,
    parameter int AUTO_FRAMES = osc_pkg::AUTO_FRAMES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    input  logic          trig_en,
    input  logic [DW-1:0] trig_level,
    input  logic          frame_start,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          bank_ready,
    output logic          capturing,
    output logic          swap_pulse
);
    import osc_pkg::*;

    localparam int ACW = $clog2(AUTO_FRAMES + 1) + 1;
    localparam logic [AW-1:0]  LAST_PTR  = AW'(SAMPLES - 1);
    localparam logic [AW:0]    SAMPLES_W = (AW+1)'(SAMPLES);
    localparam logic [ACW-1:0] AUTO_W    = ACW'(AUTO_FRAMES);

    cap_state_t     state_q, state_d;
    logic           wr_bank_q, wr_bank_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
    logic [DW-1:0]  prev_sample_q, prev_sample_d;
    logic           prev_valid_q, prev_valid_d;
    logic           bank_ready_q, bank_ready_d;
    logic           swap_pulse_q, swap_pulse_d;
    logic           rd_vld_q, rd_vld_d;

    logic           crossing;
    logic           auto_fire;
    logic           trigger;
    logic           wr_en;
    logic [AW-1:0]  wr_addr_lo;
    logic [DW-1:0]  ram_rd_data;

    assign crossing  = prev_valid_q && (prev_sample_q < trig_level) && (sample >= trig_level);
    assign auto_fire = (AUTO_FRAMES != 0) && (auto_cnt_q == AUTO_W);
    assign trigger   = sample_valid && (!trig_en || crossing || auto_fire);

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        wr_ptr_d      = wr_ptr_q;
        auto_cnt_d    = auto_cnt_q;
        prev_sample_d = prev_sample_q;
        prev_valid_d  = prev_valid_q;
        bank_ready_d  = bank_ready_q;
        swap_pulse_d  = 1'b0;
        wr_en         = 1'b0;
        wr_addr_lo    = wr_ptr_q;

        if (sample_valid) begin
            prev_sample_d = sample;
            prev_valid_d  = 1'b1;
        end

        case (state_q)
            ARMED: begin
                if (trigger) begin
                    wr_en      = 1'b1;
                    wr_addr_lo = '0;
                    wr_ptr_d   = (SAMPLES == 1) ? LAST_PTR : AW'(1);
                    state_d    = (SAMPLES == 1) ? FULL : CAPTURE;
                    auto_cnt_d = '0;
                end else if (frame_start && trig_en && (auto_cnt_q != AUTO_W)) begin
                    auto_cnt_d = auto_cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d = FULL;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            FULL: begin
                // A swap restarts trigger history so stale samples cannot form a crossing.
                if (frame_start) begin
                    wr_bank_d    = ~wr_bank_q;
                    bank_ready_d = 1'b1;
                    swap_pulse_d = 1'b1;
                    wr_ptr_d     = '0;
                    prev_valid_d = 1'b0;
                    state_d      = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase

        rd_vld_d = bank_ready_q && ({1'b0, rd_addr} < SAMPLES_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARMED;
            wr_bank_q     <= 1'b0;
            wr_ptr_q      <= '0;
            auto_cnt_q    <= '0;
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
            bank_ready_q  <= 1'b0;
            swap_pulse_q  <= 1'b0;
            rd_vld_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            auto_cnt_q    <= auto_cnt_d;
            prev_sample_q <= prev_sample_d;
            prev_valid_q  <= prev_valid_d;
            bank_ready_q  <= bank_ready_d;
            swap_pulse_q  <= swap_pulse_d;
            rd_vld_q      <= rd_vld_d;
        end
    end

    trace_ram #(
        .DW (DW),
        .AW (AW)
    ) u_trace_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank_q, wr_addr_lo}),
        .wr_data (sample),
        .rd_addr ({~wr_bank_q, rd_addr}),
        .rd_data (ram_rd_data)
    );

    assign rd_data    = rd_vld_q ? ram_rd_data : '0;
    assign bank_ready = bank_ready_q;
    assign capturing  = (state_q == CAPTURE);
    assign swap_pulse = swap_pulse_q;

endmodule

// File: doc/trace_buffer_ctrl.md
# trace_buffer_ctrl

Double-buffered sample capture controller for the oscilloscope display path. It writes incoming ADC samples into one bank of a two-bank trace memory after a trigger event. The background/trace drawing stage reads the other bank, addressed by screen column. Banks swap only at a frame boundary, so a frame never shows a partially written trace.

## Interface
Parameters:
- SAMPLES, 400, samples per trace (one per displayed column)
- DW, 12, sample width in bits
- AW, 9, address width; must satisfy 2**AW >= SAMPLES
- AUTO_FRAMES, 4, frame_start pulses spent in ARMED before a forced trigger; 0 disables auto-trigger

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  reset rst, synchronous, active-high; clock clk
- sample_valid  in  1  sample qualifies this cycle
- sample  in  DW  unsigned ADC sample
- trig_en  in  1  1 = level trigger, 0 = free-run
- trig_level  in  DW  unsigned trigger threshold
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- rd_addr  in  AW  display column index (hcount minus trace x-offset)
- rd_data  out  DW  sample at rd_addr in the display bank
- bank_ready  out  1  display bank holds a complete capture
- capturing  out  1  state == CAPTURE
- swap_pulse  out  1  one-cycle pulse on bank swap

## Operation
- Memory: 2 x SAMPLES words. wr_bank selects the capture bank; rd_bank = ~wr_bank is the display bank. Memory contents are not reset.
- Trigger detection:
  - prev_sample and prev_valid update on every sample_valid.
  - A rising crossing occurs when prev_valid, prev_sample < trig_level and sample >= trig_level.
  - The first valid sample after reset can never be a crossing.
- States: ARMED, CAPTURE, FULL.
- ARMED:
  - Entry condition: trig_en=0 with sample_valid, a crossing with trig_en=1, or a forced trigger.
  - On entry the current sample is written at address 0, wr_ptr=1, and the state moves to CAPTURE.
  - Forced trigger: auto_cnt counts frame_start pulses while in ARMED with trig_en=1. When auto_cnt reaches AUTO_FRAMES, the next sample_valid is treated as a trigger.
  - auto_cnt clears on leaving ARMED.
- CAPTURE:
  - Each sample_valid writes sample at wr_ptr, then increments wr_ptr.
  - The write at wr_ptr == SAMPLES-1 moves the state to FULL.
- FULL:
  - Samples are ignored.
  - On frame_start: wr_bank toggles, bank_ready=1, swap_pulse=1 for one cycle, wr_ptr=0, prev_valid=0, state moves to ARMED.
- frame_start outside FULL does not swap. In ARMED it only feeds auto_cnt.
- Read port:
  - rd_data = mem[rd_bank][rd_addr], registered.
  - rd_data is 0 when rd_addr >= SAMPLES or bank_ready=0.
- Comparisons are unsigned DW-bit. wr_ptr and auto_cnt saturate; they never wrap.

## Timing
- Reset values: state ARMED, wr_bank 0, wr_ptr 0, auto_cnt 0, prev_valid 0, rd_data 0, bank_ready 0, capturing 0, swap_pulse 0.
- Read latency: 1 cycle from rd_addr to rd_data.
- The trigger sample lands at address 0 in the same cycle it is presented (write is registered). capturing rises the next cycle.
- Last write coincident with frame_start: the write is accepted and the state enters FULL. The swap waits for the next frame_start; there is no same-cycle swap.
- Swap timing: rd_bank changes on the clock edge after frame_start. rd_data reflects the new bank from the following cycle, which is inside vblank.
- Reset mid-capture returns to the reset values. bank_ready stays 0 until the first complete swap.
- trig_en toggled mid-ARMED takes effect on the next sample_valid. It does not affect CAPTURE or FULL.

## Structure
- osc_pkg holds:
  - SAMPLES, DW and AW constants, shared with the trace drawing stage;
  - typedef enum logic [1:0] {ARMED, CAPTURE, FULL} cap_state_t;
  - typedef logic [DW-1:0] sample_t.
- Sub-module trace_ram: simple dual-port RAM for BRAM inference.
  - One write port: {wr_bank, wr_ptr}.
  - One registered read port: {rd_bank, rd_addr}.
  - Depth 2*2**AW.
- trace_buffer_ctrl holds the FSM, trigger compare, counters and output masking.

## Test plan
- Free-run: trig_en=0, feed 0..399 on consecutive cycles, pulse frame_start.
  - Expect swap_pulse once and bank_ready=1.
  - Expect rd_addr=123 to give rd_data=123 one cycle later.
- Level trigger: trig_level=0x800, ramp 0x700..0x900 in steps of 0x10.
  - Expect capture to start at sample 0x800, so rd_addr=0 gives 0x800 after the swap.
  - Expect samples below the crossing never stored.
- Auto-trigger: trig_en=1, constant sample 0x100, trig_level=0x800, AUTO_FRAMES=4.
  - Expect no capture during the first 4 frame_starts.
  - Expect capture to start on the next sample_valid, and a swap on the first frame_start after FULL.
- Swap gating: frame_start during CAPTURE at wr_ptr=200 gives no swap and bank_ready unchanged. Last write coincident with frame_start gives no swap until the next frame_start.
- Bounds and masking:
  - rd_addr=400 and rd_addr=511 give rd_data=0.
  - Before the first swap, any rd_addr gives 0.
  - sample_valid during FULL leaves the capture bank unchanged (checked after the next swap).
- Reset mid-capture at wr_ptr=250: all outputs return to reset values. The next full capture and swap behave as in the free-run test.
